// File: rtl/add_multiword_ctrl.sv
// add_multiword_ctrl: drives one shared N-bit combinational adder limb by limb (LSB first) to form an N*LIMBS-bit sum.
// Optional macro ADD_MULTIWORD_SUBTRACT_EN adds a req_sub input that turns the operation into A-B.
module add_multiword_ctrl #(
  parameter int N     = 32,
  parameter int LIMBS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [N*LIMBS-1:0]   req_a,
  input  logic [N*LIMBS-1:0]   req_b,
  input  logic                 req_carry_in,
`ifdef ADD_MULTIWORD_SUBTRACT_EN
  input  logic                 req_sub,
`endif
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  output logic                 add_carry_in,
  input  logic [N-1:0]         add_c,
  input  logic                 add_carry_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N*LIMBS-1:0]   rsp_sum,
  output logic                 rsp_carry_out,
  output logic                 rsp_overflow
);

  localparam int W  = N * LIMBS;
  localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IW-1:0] LAST_LIMB = IW'(LIMBS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [IW-1:0]   r_limbIdx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic [W-1:0]    w_bIn;
  logic            w_carryIn;
  logic            w_accept;
  logic [31:0]     w_base;

  // B' and the initial carry are resolved at accept time so RUN only ever adds.
`ifdef ADD_MULTIWORD_SUBTRACT_EN
  assign w_bIn     = req_sub ? ~req_b : req_b;
  assign w_carryIn = req_sub ? 1'b1 : req_carry_in;
`else
  assign w_bIn     = req_b;
  assign w_carryIn = req_carry_in;
`endif

  assign w_accept = req_valid && req_ready;
  assign w_base   = 32'(r_limbIdx) * 32'(N);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    add_a        = '0;
    add_b        = '0;
    add_carry_in = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        add_a        = r_a[w_base +: N];
        add_b        = r_b[w_base +: N];
        add_carry_in = r_carry;
        if (r_limbIdx == LAST_LIMB) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // The counter parks on the last limb; it is rewound only when a new request is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_limbIdx <= '0;
    end else if (w_accept) begin
      r_a       <= req_a;
      r_b       <= w_bIn;
      r_carry   <= w_carryIn;
      r_limbIdx <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[w_base +: N] <= add_c;
      r_carry            <= add_carry_out;
      if (r_limbIdx != LAST_LIMB) begin
        r_limbIdx <= r_limbIdx + IW'(1);
      end
    end
  end

  assign rsp_sum       = r_sum;
  assign rsp_carry_out = r_carry;
  assign rsp_overflow  = (r_a[W-1] == r_b[W-1]) && (r_sum[W-1] != r_a[W-1]);

endmodule

// File: tb/tb_add_multiword_ctrl.sv
// Directed bench for add_multiword_ctrl (N=8, LIMBS=4) with a behavioural adder and a scoreboard.
module tb_add_multiword_ctrl;

  localparam int N     = 8;
  localparam int LIMBS = 4;
  localparam int W     = N * LIMBS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          req_carry_in;
`ifdef ADD_MULTIWORD_SUBTRACT_EN
  logic          req_sub;
`endif
  logic [N-1:0]  add_a;
  logic [N-1:0]  add_b;
  logic          add_carry_in;
  logic [N-1:0]  add_c;
  logic          add_carry_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_sum;
  logic          rsp_carry_out;
  logic          rsp_overflow;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  add_multiword_ctrl #(.N(N), .LIMBS(LIMBS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_carry_in  (req_carry_in),
`ifdef ADD_MULTIWORD_SUBTRACT_EN
    .req_sub       (req_sub),
`endif
    .add_a         (add_a),
    .add_b         (add_b),
    .add_carry_in  (add_carry_in),
    .add_c         (add_c),
    .add_carry_out (add_carry_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_sum       (rsp_sum),
    .rsp_carry_out (rsp_carry_out),
    .rsp_overflow  (rsp_overflow)
  );

  // Stand-in for the shared combinational adder.
  assign {add_carry_out, add_c} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_carry_in};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for req_ready, presents one request for exactly one accept edge and records the model result.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int          waitCnt;
    logic [W-1:0] bp;
    logic        c0;
    logic [W:0]  full;
    exp_t        e;
    waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!req_ready) checkEq("req_ready_timeout", 64'(req_ready), 64'd1);
    bp   = sub ? ~b : b;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c0};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
    req_valid    = 1'b1;
    req_a        = a;
    req_b        = b;
    req_carry_in = cin;
`ifdef ADD_MULTIWORD_SUBTRACT_EN
    req_sub      = sub;
`endif
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back(e);
  endtask

  // Waits for the response, compares it with the scoreboard, optionally stalls, then hands it off.
  task automatic checkOutput(input bit checkLatency, input int holdCycles);
    int   lat;
    exp_t e;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      checkEq("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
      return;
    end
    if (checkLatency) checkEq("latency_edges", 64'(lat), 64'(LIMBS));
    if (sb.size() == 0) begin
      checkEq("scoreboard_empty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    checkEq("rsp_sum", 64'(rsp_sum), 64'(e.sum));
    checkEq("rsp_carry_out", 64'(rsp_carry_out), 64'(e.cout));
    checkEq("rsp_overflow", 64'(rsp_overflow), 64'(e.ovf));
    checkEq("done_req_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < holdCycles; i++) begin
      req_valid = 1'b1;
      req_a     = 32'hDEAD_BEEF;
      req_b     = 32'h1234_5678;
      @(posedge clk); #1;
      checkEq($sformatf("hold%0d_valid", i), 64'(rsp_valid), 64'd1);
      checkEq($sformatf("hold%0d_sum", i), 64'(rsp_sum), 64'(e.sum));
      checkEq($sformatf("hold%0d_cout", i), 64'(rsp_carry_out), 64'(e.cout));
      checkEq($sformatf("hold%0d_ovf", i), 64'(rsp_overflow), 64'(e.ovf));
      checkEq($sformatf("hold%0d_req_ready", i), 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkEq("release_req_ready", 64'(req_ready), 64'd1);
    checkEq("release_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic sawValid;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_a        = '0;
    req_b        = '0;
    req_carry_in = 1'b0;
`ifdef ADD_MULTIWORD_SUBTRACT_EN
    req_sub      = 1'b0;
`endif
    rsp_ready    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkEq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkEq("reset_rsp_sum", 64'(rsp_sum), 64'd0);
    checkEq("reset_rsp_cout", 64'(rsp_carry_out), 64'd0);
    checkEq("reset_rsp_ovf", 64'(rsp_overflow), 64'd0);
    checkEq("reset_req_ready", 64'(req_ready), 64'd1);
    checkEq("reset_add_a", 64'(add_a), 64'd0);
    checkEq("reset_add_b", 64'(add_b), 64'd0);
    checkEq("reset_add_cin", 64'(add_carry_in), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] carry ripple");
    applyStimulus(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput(1'b1, 0);

    $display("[TB] signed overflow and unsigned wrap");
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput(1'b1, 0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput(1'b1, 0);

    $display("[TB] backpressure");
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    checkOutput(1'b0, 10);

    $display("[TB] random operands");
    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      checkOutput(1'b1, 0);
    end

    $display("[TB] reset mid-operation");
    applyStimulus(32'hA1B2_C3D4, 32'h0101_0101, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkEq("midop_add_a_limb1", 64'(add_a), 64'h00C3);
    checkEq("midop_add_b_limb1", 64'(add_b), 64'h0001);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    checkEq("midop_req_ready", 64'(req_ready), 64'd1);
    checkEq("midop_rsp_valid", 64'(rsp_valid), 64'd0);
    checkEq("midop_rsp_sum", 64'(rsp_sum), 64'd0);
    checkEq("midop_add_a", 64'(add_a), 64'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      sawValid = sawValid | rsp_valid;
    end
    checkEq("midop_no_rsp", 64'(sawValid), 64'd0);
    applyStimulus(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    checkOutput(1'b1, 0);

`ifdef ADD_MULTIWORD_SUBTRACT_EN
    $display("[TB] subtract");
    applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
    checkOutput(1'b1, 0);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    checkOutput(1'b1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
